// File: rtl/load_store_unit.sv
// Load/store unit: checks, issues and completes one load or store to a req/ack data memory.
// Latency: accept T, oMemReq from T+1, result pulse one cycle after iMemAck; exceptions in T+1.
// Backpressure: oReqReady only in IDLE, one outstanding access, bus timeout after TIMEOUT_CYCLES.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic        iReqWrite,
  input  logic [2:0]  iReqFunct3,
  input  logic [31:0] iReqAddr,
  input  logic [31:0] iReqWData,
  input  logic [4:0]  iReqRd,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [3:0]  oMemBe,
  output logic [31:0] oMemWData,
  input  logic        iMemAck,
  input  logic [31:0] iMemRData,
  output logic        oWbValid,
  output logic [4:0]  oWbRd,
  output logic [31:0] oWbData,
  output logic        oStoreDone,
  output logic        oExcValid,
  output logic [1:0]  oExcCode,
  output logic [31:0] oExcAddr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_EXC} state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [1:0]  exc_code_q, exc_code_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  logic        req_illegal, req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata, ld_shift, ld_data;

  // Decode the incoming request: legality, alignment, lane enables and replicated store data.
  always_comb begin
    req_illegal    = (iReqFunct3 == 3'b011) || (iReqFunct3 == 3'b110) ||
                     (iReqFunct3 == 3'b111) || (iReqFunct3[2] && iReqWrite);
    req_misaligned = ((iReqFunct3[1:0] == 2'b01) && iReqAddr[0]) ||
                     ((iReqFunct3[1:0] == 2'b10) && (iReqAddr[1:0] != 2'b00));
    case (iReqFunct3[1:0])
      2'b00:   begin req_be = 4'b0001 << iReqAddr[1:0]; req_wdata = {4{iReqWData[7:0]}};  end
      2'b01:   begin req_be = 4'b0011 << iReqAddr[1:0]; req_wdata = {2{iReqWData[15:0]}}; end
      default: begin req_be = 4'b1111;                  req_wdata = iReqWData;            end
    endcase
  end

  // Shift the read word down to the addressed lane and extend per access size.
  always_comb begin
    ld_shift = iMemRData >> {req_addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = iMemRData;
    endcase
  end

  // Next-state logic for the transaction FSM and its captured request/result registers.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    req_addr_d  = req_addr_q;
    rd_d        = rd_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    exc_code_d  = exc_code_q;
    exc_addr_d  = exc_addr_q;
    case (state_q)
      S_IDLE: begin
        if (iReqValid) begin
          we_d        = iReqWrite;
          f3_d        = iReqFunct3;
          req_addr_d  = iReqAddr;
          rd_d        = iReqRd;
          mem_be_d    = req_be;
          mem_wdata_d = req_wdata;
          cnt_d       = 8'd0;
          if (req_illegal) begin
            state_d    = S_EXC;
            exc_code_d = 2'b10;
            exc_addr_d = iReqAddr;
          end else if (req_misaligned) begin
            state_d    = S_EXC;
            exc_code_d = 2'b01;
            exc_addr_d = iReqAddr;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // An ack in the same cycle as the timeout limit still completes the access.
        if (iMemAck) begin
          state_d = S_RESP;
          if (!we_q) begin
            wb_rd_d   = rd_q;
            wb_data_d = ld_data;
          end
        end else if (cnt_q == TIMEOUT_LIM) begin
          state_d    = S_EXC;
          exc_code_d = 2'b11;
          exc_addr_d = req_addr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register all state; reset aborts any transaction in flight.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      req_addr_q  <= 32'h0;
      rd_q        <= 5'd0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      cnt_q       <= 8'd0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'h0;
      exc_code_q  <= 2'b00;
      exc_addr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      req_addr_q  <= req_addr_d;
      rd_q        <= rd_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      exc_code_q  <= exc_code_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign oReqReady  = (state_q == S_IDLE);
  assign oMemReq    = (state_q == S_REQ);
  assign oMemWe     = we_q;
  assign oMemAddr   = {req_addr_q[31:2], 2'b00};
  assign oMemBe     = mem_be_q;
  assign oMemWData  = mem_wdata_q;
  assign oWbValid   = (state_q == S_RESP) && !we_q;
  assign oStoreDone = (state_q == S_RESP) && we_q;
  assign oWbRd      = wb_rd_q;
  assign oWbData    = wb_data_q;
  assign oExcValid  = (state_q == S_EXC);
  assign oExcCode   = exc_code_q;
  assign oExcAddr   = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests, scoreboarded responses and memory requests.
// A memory responder acks after a programmable latency (0 = never).
// Responses and memory requests are compared in separate monitor processes.
module tb_load_store_unit;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iReqValid, iReqWrite;
  logic [2:0]  iReqFunct3;
  logic [31:0] iReqAddr, iReqWData;
  logic [4:0]  iReqRd;
  logic        oReqReady, oMemReq, oMemWe;
  logic [31:0] oMemAddr, oMemWData;
  logic [3:0]  oMemBe;
  logic        iMemAck;
  logic [31:0] iMemRData;
  logic        oWbValid, oStoreDone, oExcValid;
  logic [4:0]  oWbRd;
  logic [31:0] oWbData, oExcAddr;
  logic [1:0]  oExcCode;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqWrite(iReqWrite),
    .iReqFunct3(iReqFunct3), .iReqAddr(iReqAddr), .iReqWData(iReqWData), .iReqRd(iReqRd),
    .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemBe(oMemBe),
    .oMemWData(oMemWData), .iMemAck(iMemAck), .iMemRData(iMemRData),
    .oWbValid(oWbValid), .oWbRd(oWbRd), .oWbData(oWbData), .oStoreDone(oStoreDone),
    .oExcValid(oExcValid), .oExcCode(oExcCode), .oExcAddr(oExcAddr)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int          kind;   // 0 writeback, 1 store done, 2 exception
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  code;
    logic [31:0] addr;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mreq_t;

  resp_t exp_q[$];
  mreq_t mem_q[$];

  int total = 0;
  int bad = 0;
  int spurious = 0;
  int ack_lat = 1;
  int req_len = 0;
  int late_ack_tok = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever a result or exception pulse appears.
  initial begin
    resp_t e;
    forever begin
      @(negedge iClk);
      if (!iRst && (oWbValid || oStoreDone || oExcValid)) begin
        if (exp_q.size() == 0) begin
          spurious++;
          chk("unexpected_pulse", {29'h0, oWbValid, oStoreDone, oExcValid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {29'h0, oWbValid, oStoreDone, oExcValid},
              (e.kind == 0) ? 32'h4 : (e.kind == 1) ? 32'h2 : 32'h1);
          if (e.kind == 0) begin
            chk("wb_rd", {27'h0, oWbRd}, {27'h0, e.rd});
            chk("wb_data", oWbData, e.data);
          end else if (e.kind == 2) begin
            chk("exc_code", {30'h0, oExcCode}, {30'h0, e.code});
            chk("exc_addr", oExcAddr, e.addr);
          end
        end
      end
    end
  end

  // Memory responder: checks each new request against the queue and acks after ack_lat cycles.
  initial begin
    mreq_t m;
    bit    in_req = 0;
    int    wait_cnt = 0;
    int    tok_seen = 0;
    iMemAck   = 1'b0;
    iMemRData = 32'h0;
    m = '{we: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0, rdata: 32'h0};
    forever begin
      @(negedge iClk);
      iMemAck = 1'b0;
      if (late_ack_tok != tok_seen) begin
        tok_seen  = late_ack_tok;
        iMemAck   = 1'b1;
        iMemRData = 32'hDEAD_0000;
      end else if (oMemReq && !iRst) begin
        if (!in_req) begin
          in_req   = 1;
          wait_cnt = 0;
          if (mem_q.size() == 0) begin
            chk("unexpected_mem_req", oMemAddr, 32'hFFFF_FFFF);
          end else begin
            m = mem_q.pop_front();
            chk("mem_we", {31'h0, oMemWe}, {31'h0, m.we});
            chk("mem_addr", oMemAddr, m.addr);
            chk("mem_be", {28'h0, oMemBe}, {28'h0, m.be});
            if (m.we) chk("mem_wdata", oMemWData, m.wdata);
          end
        end
        wait_cnt++;
        if (ack_lat != 0 && wait_cnt == ack_lat) begin
          iMemAck   = 1'b1;
          iMemRData = m.rdata;
        end
      end else begin
        if (in_req) req_len = wait_cnt;
        in_req = 0;
      end
    end
  end

  // Present one request (valid stays high afterwards) and queue its expectations.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input int kind, input logic [31:0] exp_data, input logic [1:0] code,
                       input bit has_mem, input logic [3:0] be, input logic [31:0] mwd,
                       input logic [31:0] rdata);
    int budget = 0;
    @(negedge iClk);
    iReqValid  = 1'b1;
    iReqWrite  = w;
    iReqFunct3 = f3;
    iReqAddr   = a;
    iReqWData  = wd;
    iReqRd     = rd;
    if (kind >= 0) exp_q.push_back('{kind: kind, rd: rd, data: exp_data, code: code, addr: a});
    if (has_mem) mem_q.push_back('{we: w, addr: {a[31:2], 2'b00}, be: be, wdata: mwd, rdata: rdata});
    while (!oReqReady && budget < 100) begin
      @(negedge iClk);
      budget++;
    end
    if (!oReqReady) chk("ready_timeout", 32'h0, 32'h1);
    @(negedge iClk);
    chk("ready_low_after_accept", {31'h0, oReqReady}, 32'h0);
  endtask

  task automatic drain();
    int budget = 0;
    iReqValid = 1'b0;
    while ((exp_q.size() != 0 || !oReqReady) && budget < 200) begin
      @(negedge iClk);
      budget++;
    end
    if (budget >= 200) chk("drain_timeout", exp_q.size(), 32'h0);
  endtask

  initial begin
    iRst = 1'b1; iReqValid = 1'b0; iReqWrite = 1'b0; iReqFunct3 = 3'b000;
    iReqAddr = 32'h0; iReqWData = 32'h0; iReqRd = 5'd0;
    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    chk("rst_ready", {31'h0, oReqReady}, 32'h1);
    chk("rst_outputs", {27'h0, oMemReq, oMemWe, oWbValid, oStoreDone, oExcValid}, 32'h0);
    chk("rst_mem_addr_be", oMemAddr | {28'h0, oMemBe}, 32'h0);
    chk("rst_wb_data", oWbData, 32'h0);
    chk("rst_exc", oExcAddr | {30'h0, oExcCode}, 32'h0);

    // Zero-wait memory: LB / LBU from 0x103, stores SH, SB, SW.
    ack_lat = 1;
    issue(0, 3'b000, 32'h103, 32'h0, 5'd5, 0, 32'hFFFF_FF80, 2'b00, 1, 4'b1000, 32'h0, 32'h80FF_1234);
    drain();
    issue(0, 3'b100, 32'h103, 32'h0, 5'd6, 0, 32'h0000_0080, 2'b00, 1, 4'b1000, 32'h0, 32'h80FF_1234);
    drain();
    issue(1, 3'b001, 32'h202, 32'h0000_BEEF, 5'd0, 1, 32'h0, 2'b00, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    drain();
    issue(1, 3'b000, 32'h001, 32'h1234_56A5, 5'd0, 1, 32'h0, 2'b00, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    drain();
    issue(1, 3'b010, 32'h010, 32'hDEAD_BEEF, 5'd0, 1, 32'h0, 2'b00, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    drain();

    // Exceptions without memory access.
    issue(0, 3'b010, 32'h206, 32'h0, 5'd3, 2, 32'h0, 2'b01, 0, 4'h0, 32'h0, 32'h0);
    drain();
    issue(1, 3'b100, 32'h040, 32'h0, 5'd3, 2, 32'h0, 2'b10, 0, 4'h0, 32'h0, 32'h0);
    drain();
    issue(0, 3'b111, 32'h044, 32'h0, 5'd3, 2, 32'h0, 2'b10, 0, 4'h0, 32'h0, 32'h0);
    drain();

    // Back-to-back LH / LHU, 3-cycle ack, valid held high between them.
    ack_lat = 3;
    issue(0, 3'b001, 32'h402, 32'h0, 5'd7, 0, 32'hFFFF_8001, 2'b00, 1, 4'b1100, 32'h0, 32'h8001_7FFF);
    issue(0, 3'b101, 32'h400, 32'h0, 5'd8, 0, 32'h0000_F00D, 2'b00, 1, 4'b0011, 32'h0, 32'h1234_F00D);
    drain();
    chk("b2b_mem_q_empty", mem_q.size(), 32'h0);

    // Timeout: request held TIMEOUT_CYCLES+1 = 5 cycles, then code 11; late ack ignored.
    ack_lat = 0;
    issue(0, 3'b010, 32'h300, 32'h0, 5'd9, 2, 32'h0, 2'b11, 1, 4'b1111, 32'h0, 32'h0);
    drain();
    chk("timeout_req_len", req_len, 32'd5);
    late_ack_tok++;
    repeat (4) @(negedge iClk);

    // Reset during REQ aborts silently; next load (rd=0) completes.
    issue(0, 3'b010, 32'h500, 32'h0, 5'd4, -1, 32'h0, 2'b00, 1, 4'b1111, 32'h0, 32'h0);
    iReqValid = 1'b0;
    chk("req_before_rst", {31'h0, oMemReq}, 32'h1);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    chk("rst_mid_memreq", {31'h0, oMemReq}, 32'h0);
    chk("rst_mid_ready", {31'h0, oReqReady}, 32'h1);
    ack_lat = 2;
    issue(0, 3'b010, 32'h504, 32'h0, 5'd0, 0, 32'hCAFE_F00D, 2'b00, 1, 4'b1111, 32'h0, 32'hCAFE_F00D);
    drain();

    repeat (3) @(negedge iClk);
    chk("no_spurious_pulses", spurious, 32'h0);
    chk("mem_q_empty", mem_q.size(), 32'h0);
    chk("exp_q_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
